// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle RV32 subset controller: FSM states,
// opcodes, datapath select codes and the bundled control-word type.
package riscv_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXECUTE  = 4'd6,
    ALU_WB   = 4'd7,
    BRANCH   = 4'd8
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REGA  = 2'b10;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  // Unqualified per-state control word; handshake/flag gating happens in the top.
  typedef struct packed {
    logic       pc_en;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_R) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/mc_out_dec.sv
// State-to-control-word decoder for the multi-cycle controller (pure combinational).
// pc_en/ir_write are raised unconditionally here; the top qualifies them.
module mc_out_dec
  import riscv_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      FETCH: begin
        ctrl.mem_read   = 1'b1;
        ctrl.iord       = 1'b0;
        ctrl.ir_write   = 1'b1;
        ctrl.pc_en      = 1'b1;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALU_ADD;
        ctrl.result_src = RES_ALU;
      end
      DECODE: begin
        // Branch target is computed speculatively into ALU-out.
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      MEM_ADDR: begin
        ctrl.alu_src_a = SRCA_REGA;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      MEM_RD: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      MEM_WB: begin
        ctrl.result_src = RES_MEMDATA;
        ctrl.reg_write  = 1'b1;
      end
      MEM_WR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      EXECUTE: begin
        ctrl.alu_src_a = SRCA_REGA;
        ctrl.alu_src_b = SRCB_REGB;
        ctrl.alu_op    = ALU_FUNCT;
      end
      ALU_WB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a  = SRCA_REGA;
        ctrl.alu_src_b  = SRCB_REGB;
        ctrl.alu_op     = ALU_SUB;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_en      = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multi-cycle main control FSM for lw/sw/R-type/beq: state register, next-state
// logic, memory handshake and zero-flag gating, reset masking and retire counter.
module mc_main_ctrl
  import riscv_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  input  logic             zero,
  output logic             pc_en,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_op,
  output logic             illegal_instr,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state_o
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] instret_reg;
  logic             retire;
  logic             illegal;
  ctrl_t            dec;

  mc_out_dec u_out_dec (
    .state (state_reg),
    .ctrl  (dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= FETCH;
      instret_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (retire) begin
        instret_reg <= instret_reg + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    retire     = 1'b0;
    illegal    = 1'b0;
    unique case (state_reg)
      FETCH: begin
        if (mem_ready) state_next = DECODE;
      end
      DECODE: begin
        unique case (opcode)
          OP_LW, OP_SW: state_next = MEM_ADDR;
          OP_R:         state_next = EXECUTE;
          OP_BEQ:       state_next = BRANCH;
          default: begin
            state_next = FETCH;
            illegal    = 1'b1;
          end
        endcase
      end
      MEM_ADDR: begin
        state_next = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        if (mem_ready) state_next = MEM_WB;
      end
      MEM_WB: begin
        state_next = FETCH;
        retire     = 1'b1;
      end
      MEM_WR: begin
        // Stores retire on the handshake cycle itself; there is no writeback step.
        if (mem_ready) begin
          state_next = FETCH;
          retire     = 1'b1;
        end
      end
      EXECUTE: begin
        state_next = ALU_WB;
      end
      ALU_WB: begin
        state_next = FETCH;
        retire     = 1'b1;
      end
      BRANCH: begin
        state_next = FETCH;
        retire     = 1'b1;
      end
      default: state_next = FETCH;
    endcase
  end

  logic pc_qual;

  always_comb begin
    pc_qual = 1'b1;
    if (state_reg == FETCH)  pc_qual = mem_ready;
    if (state_reg == BRANCH) pc_qual = zero;
  end

  // Reset masks every output in the same cycle, including a pending write strobe.
  always_comb begin
    pc_en         = ~rst & dec.pc_en & pc_qual;
    ir_write      = ~rst & dec.ir_write & mem_ready;
    iord          = ~rst & dec.iord;
    mem_read      = ~rst & dec.mem_read;
    mem_write     = ~rst & dec.mem_write;
    reg_write     = ~rst & dec.reg_write;
    alu_src_a     = rst ? 2'b00 : dec.alu_src_a;
    alu_src_b     = rst ? 2'b00 : dec.alu_src_b;
    result_src    = rst ? 2'b00 : dec.result_src;
    alu_op        = rst ? 2'b00 : dec.alu_op;
    illegal_instr = ~rst & illegal;
    instret       = rst ? '0 : instret_reg;
    state_o       = rst ? 4'd0 : state_reg;
  end

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Scoreboard bench for mc_main_ctrl: an instruction-level reference model expands
// each instruction into its expected per-cycle control trace; a monitor checks it.
module tb_mc_main_ctrl;
  import riscv_pkg::*;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [6:0]    opcode = '0;
  logic          mem_ready = 1'b0;
  logic          zero = 1'b0;
  logic          pc_en, ir_write, iord, mem_read, mem_write, reg_write;
  logic [1:0]    alu_src_a, alu_src_b, result_src, alu_op;
  logic          illegal_instr;
  logic [CW-1:0] instret;
  logic [3:0]    state_o;

  mc_main_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
    .pc_en(pc_en), .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .result_src(result_src), .alu_op(alu_op),
    .illegal_instr(illegal_instr), .instret(instret), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    st;
    logic [14:0]   ctl;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   model_cnt = 0;

  function automatic logic [14:0] mk(input logic pe, input logic iw, input logic io,
                                     input logic mr, input logic mw, input logic rw,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] rs, input logic [1:0] op,
                                     input logic il);
    return {pe, iw, io, mr, mw, rw, a, b, rs, op, il};
  endfunction

  // One clock of stimulus plus the outputs that cycle must show.
  task automatic step(input logic r, input logic [6:0] opc, input logic rdy, input logic z,
                      input logic [3:0] st, input logic [14:0] ctl, input logic ret);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; opcode = opc; mem_ready = rdy; zero = z;
    if (r) begin
      e = '0;
      model_cnt = 0;
    end else begin
      e.st  = st;
      e.ctl = ctl;
      e.cnt = CW'(model_cnt);
      if (ret) model_cnt = (model_cnt + 1) % (1 << CW);
    end
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 7'($urandom), 1'($urandom), 1'($urandom), 4'd0, '0, 1'b0);
  endtask

  task automatic fetch(input int fw);
    for (int i = 0; i <= fw; i++) begin
      step(1'b0, 7'($urandom), i == fw, 1'($urandom), FETCH,
           mk(i == fw, i == fw, 0, 1, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0), 1'b0);
    end
  endtask

  task automatic instr(input logic [6:0] opc, input int fw, input int mw, input logic z);
    logic legal;
    legal = (opc == 7'b0000011) || (opc == 7'b0100011) || (opc == 7'b0110011) || (opc == 7'b1100011);
    fetch(fw);
    step(1'b0, opc, 1'($urandom), 1'($urandom), DECODE,
         mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b00, !legal), 1'b0);
    if (!legal) return;
    if (opc == 7'b0110011) begin
      step(1'b0, opc, 1'($urandom), 1'($urandom), EXECUTE,
           mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b10, 0), 1'b0);
      step(1'b0, opc, 1'($urandom), 1'($urandom), ALU_WB,
           mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0), 1'b1);
    end else if (opc == 7'b1100011) begin
      step(1'b0, opc, 1'($urandom), z, BRANCH,
           mk(z, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b01, 0), 1'b1);
    end else begin
      step(1'b0, opc, 1'($urandom), 1'($urandom), MEM_ADDR,
           mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 2'b00, 2'b00, 0), 1'b0);
      for (int i = 0; i <= mw; i++) begin
        if (opc == 7'b0000011)
          step(1'b0, opc, i == mw, 1'($urandom), MEM_RD,
               mk(0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0), 1'b0);
        else
          step(1'b0, opc, i == mw, 1'($urandom), MEM_WR,
               mk(0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0), i == mw);
      end
      if (opc == 7'b0000011)
        step(1'b0, opc, 1'($urandom), 1'($urandom), MEM_WB,
             mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 2'b00, 0), 1'b1);
    end
  endtask

  // Monitor: the controller presents a control word every cycle.
  always @(negedge clk) begin
    exp_t e;
    logic [14:0] got_ctl;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got_ctl = {pc_en, ir_write, iord, mem_read, mem_write, reg_write,
                 alu_src_a, alu_src_b, result_src, alu_op, illegal_instr};
      checks++;
      if (state_o !== e.st) begin
        errors++;
        $display("FAIL state cyc=%0d got %0d want %0d", cyc, state_o, e.st);
      end
      checks++;
      if (got_ctl !== e.ctl) begin
        errors++;
        $display("FAIL ctrl cyc=%0d got %b want %b", cyc, got_ctl, e.ctl);
      end
      checks++;
      if (instret !== e.cnt) begin
        errors++;
        $display("FAIL instret cyc=%0d got %0d want %0d", cyc, instret, e.cnt);
      end
    end
  end

  initial begin
    logic [6:0] ops[4];
    logic [6:0] bad;
    int         sel;
    ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011; ops[3] = 7'b1100011;

    do_reset(2);
    instr(7'b0110011, 0, 0, 1'b0);
    instr(7'b0000011, 2, 1, 1'b0);
    instr(7'b1100011, 0, 0, 1'b1);
    instr(7'b1100011, 0, 0, 1'b0);
    instr(7'b0100011, 1, 2, 1'b0);

    // Store abandoned by reset while still waiting on memory.
    fetch(0);
    step(1'b0, 7'b0100011, 1'b0, 1'b0, DECODE, mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b00, 0), 1'b0);
    step(1'b0, 7'b0100011, 1'b0, 1'b0, MEM_ADDR, mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 2'b00, 2'b00, 0), 1'b0);
    step(1'b0, 7'b0100011, 1'b0, 1'b0, MEM_WR, mk(0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0), 1'b0);
    step(1'b1, 7'b0100011, 1'b0, 1'b0, 4'd0, '0, 1'b0);

    instr(7'b0110011, 0, 0, 1'b0);
    instr(7'b1111111, 0, 0, 1'b0);

    // Counter wrap: 17 retirements on a 4-bit counter leaves 1.
    do_reset(1);
    for (int i = 0; i < 17; i++) instr(7'b0110011, 0, 0, 1'b0);
    instr(7'b1111111, 1, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 5);
      if (sel < 4) begin
        instr(ops[sel], $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
      end else begin
        bad = 7'($urandom);
        while ((bad == ops[0]) || (bad == ops[1]) || (bad == ops[2]) || (bad == ops[3])) bad = 7'($urandom);
        instr(bad, $urandom_range(0, 2), 0, 1'b0);
      end
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
